issue_scoreboard: RTL and testbench

- Issue stage between fetch and execute.
- Accepts raw 32-bit instructions and decodes them with an internal `decoder` instance.
- Tracks outstanding register writes in a per-register scoreboard for the scalar and predicate banks. Stalls on RAW/WAW hazards, serialises branches until they resolve, and drains the pipeline on HALT.
- Emits one instruction per cycle at most, through a single registered output slot.

---
 rtl/issue_scoreboard_pkg.sv | 47 ++++
 rtl/issue_scoreboard_decoder.sv | 31 +++
 rtl/issue_scoreboard.sv | 138 +++++++++++++
 tb/tb_issue_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue stage: instruction field layout, opcodes,
// register bank selectors, scoreboard defaults and issue FSM states.
package issue_scoreboard_pkg;

    localparam int WIDTH   = 32;
    localparam int REG_SEL = 5;
    localparam int P_SEL   = 4;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 9;

    localparam int DEF_S_NREGS = 32;
    localparam int DEF_P_NREGS = 16;
    localparam int DEF_CNT_W   = 32;

    localparam logic S_REGS = 1'b0;
    localparam logic P_REGS = 1'b1;

    // {op[31:28], z_sel[27], z_addr[26:22], a_from[21], a_sel[20], a_addr[19:15],
    //  b_from[14], b_addr[13:9], imm[8:0]}
    localparam int OP_LSB     = 28;
    localparam int Z_SEL_BIT  = 27;
    localparam int Z_ADDR_LSB = 22;
    localparam int A_FROM_BIT = 21;
    localparam int A_SEL_BIT  = 20;
    localparam int A_ADDR_LSB = 15;
    localparam int B_FROM_BIT = 14;
    localparam int B_ADDR_LSB = 9;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h2;
    localparam logic [OP_W-1:0] OP_CMP  = 4'h3;
    localparam logic [OP_W-1:0] OP_BR   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT = 4'h5;

    typedef enum logic [1:0] {
        ISS_RUN,
        ISS_BR_WAIT,
        ISS_DRAIN,
        ISS_HALTED
    } iss_state_t;

    function automatic logic op_writes(input logic [OP_W-1:0] op);
        return (op != OP_BR) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/issue_scoreboard_decoder.sv
// Field extraction for raw instruction words; purely combinational.
module decoder
    import issue_scoreboard_pkg::*;
(
    input  logic [WIDTH-1:0]   inst,
    output logic [OP_W-1:0]    opcode,
    output logic               a_from_regbank,
    output logic               a_regbank_sel,
    output logic [REG_SEL-1:0] a_regbank_addr,
    output logic               b_from_regbank,
    output logic [REG_SEL-1:0] b_regbank_addr,
    output logic               z_regbank_sel,
    output logic [REG_SEL-1:0] z_regbank_addr
);

    // The immediate is consumed by execute, never by issue.
    logic unused_imm;

    always_comb begin
        opcode         = inst[OP_LSB +: OP_W];
        z_regbank_sel  = inst[Z_SEL_BIT];
        z_regbank_addr = inst[Z_ADDR_LSB +: REG_SEL];
        a_from_regbank = inst[A_FROM_BIT];
        a_regbank_sel  = inst[A_SEL_BIT];
        a_regbank_addr = inst[A_ADDR_LSB +: REG_SEL];
        b_from_regbank = inst[B_FROM_BIT];
        b_regbank_addr = inst[B_ADDR_LSB +: REG_SEL];
        unused_imm     = ^inst[IMM_W-1:0];
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: decodes fetched instructions, tracks outstanding register
// writes per bank, stalls on hazards, serialises branches and drains on HALT.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int S_NREGS = DEF_S_NREGS,
    parameter int P_NREGS = DEF_P_NREGS,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_inst,
    input  logic               wb_valid,
    input  logic               wb_regbank_sel,
    input  logic [REG_SEL-1:0] wb_addr,
    input  logic               br_resolve,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cycles
);

    logic [OP_W-1:0]    dec_op;
    logic               dec_a_from;
    logic               dec_a_sel;
    logic [REG_SEL-1:0] dec_a_addr;
    logic               dec_b_from;
    logic [REG_SEL-1:0] dec_b_addr;
    logic               dec_z_sel;
    logic [REG_SEL-1:0] dec_z_addr;

    decoder u_decoder (
        .inst           (in_inst),
        .opcode         (dec_op),
        .a_from_regbank (dec_a_from),
        .a_regbank_sel  (dec_a_sel),
        .a_regbank_addr (dec_a_addr),
        .b_from_regbank (dec_b_from),
        .b_regbank_addr (dec_b_addr),
        .z_regbank_sel  (dec_z_sel),
        .z_regbank_addr (dec_z_addr)
    );

    iss_state_t         state;
    iss_state_t         state_nxt;
    logic [S_NREGS-1:0] busy_s;
    logic [S_NREGS-1:0] busy_s_nxt;
    logic [P_NREGS-1:0] busy_p;
    logic [P_NREGS-1:0] busy_p_nxt;

    logic dec_writes;
    logic is_br;
    logic is_halt;
    logic a_busy;
    logic b_busy;
    logic z_busy;
    logic hazard;
    logic accept;
    logic all_idle;

    // Hazards look only at registered busy bits: a writeback this cycle
    // frees its register for the next cycle, not this one.
    always_comb begin
        dec_writes = op_writes(dec_op);
        is_br      = (dec_op == OP_BR);
        is_halt    = (dec_op == OP_HALT);
        a_busy     = dec_a_from &&
                     ((dec_a_sel == P_REGS) ? busy_p[dec_a_addr[P_SEL-1:0]]
                                            : busy_s[dec_a_addr]);
        b_busy     = dec_b_from && busy_s[dec_b_addr];
        z_busy     = dec_writes &&
                     ((dec_z_sel == P_REGS) ? busy_p[dec_z_addr[P_SEL-1:0]]
                                            : busy_s[dec_z_addr]);
        hazard     = a_busy || b_busy || z_busy;
        in_ready   = (state == ISS_RUN) && !hazard && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        all_idle   = (busy_s == '0) && (busy_p == '0) && !out_valid;
        halted     = (state == ISS_HALTED);
    end

    // Clear first, then set, so an issuing write beats a same-cycle retire.
    always_comb begin
        busy_s_nxt = busy_s;
        busy_p_nxt = busy_p;
        if (wb_valid) begin
            if (wb_regbank_sel == P_REGS) busy_p_nxt[wb_addr[P_SEL-1:0]] = 1'b0;
            else                          busy_s_nxt[wb_addr]            = 1'b0;
        end
        if (accept && dec_writes) begin
            if (dec_z_sel == P_REGS) busy_p_nxt[dec_z_addr[P_SEL-1:0]] = 1'b1;
            else                     busy_s_nxt[dec_z_addr]            = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ISS_RUN: begin
                if (accept && is_br)        state_nxt = ISS_BR_WAIT;
                else if (accept && is_halt) state_nxt = ISS_DRAIN;
            end
            ISS_BR_WAIT: if (br_resolve) state_nxt = ISS_RUN;
            ISS_DRAIN:   if (all_idle)   state_nxt = ISS_HALTED;
            ISS_HALTED:  state_nxt = ISS_HALTED;
            default:     state_nxt = ISS_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ISS_RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_s       <= '0;
            busy_p       <= '0;
            out_valid    <= 1'b0;
            out_inst     <= '0;
            stall_cycles <= '0;
        end else begin
            busy_s <= busy_s_nxt;
            busy_p <= busy_p_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_inst  <= in_inst;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && !in_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed hazard/branch/halt scenarios
// followed by randomized traffic, checked against a cycle-level reference model.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        wb_valid = 1'b0;
    logic        wb_regbank_sel = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        br_resolve = 1'b0;
    logic        halted;
    logic [31:0] stall_cycles;

    issue_scoreboard #(.S_NREGS(32), .P_NREGS(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .wb_valid(wb_valid), .wb_regbank_sel(wb_regbank_sel), .wb_addr(wb_addr),
        .br_resolve(br_resolve), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: which registers have an outstanding write, plus flags
    // for "waiting on a branch", "draining for halt" and "halted".
    bit          m_busy_s[32];
    bit          m_busy_p[16];
    bit          m_br_wait, m_draining, m_halted, m_out_valid;
    logic [31:0] m_stall;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input bit zb, input logic [4:0] za,
                                       input bit af, input bit ab, input logic [4:0] aa,
                                       input bit bf, input logic [4:0] ba);
        logic [8:0] imm = 9'($urandom);
        return {op, zb, za, af, ab, aa, bf, ba, imm};
    endfunction

    function automatic bit writes(input logic [31:0] inst);
        logic [3:0] op = inst[31:28];
        return !(op == OP_BR || op == OP_HALT);
    endfunction

    function automatic bit reg_busy(input bit bank, input logic [4:0] addr);
        if (bank) return m_busy_p[addr[3:0]];
        return m_busy_s[addr];
    endfunction

    function automatic bit m_hazard(input logic [31:0] inst);
        bit ha = inst[21] && reg_busy(inst[20], inst[19:15]);
        bit hb = inst[14] && reg_busy(1'b0, inst[13:9]);
        bit hz = writes(inst) && reg_busy(inst[27], inst[26:22]);
        return ha || hb || hz;
    endfunction

    function automatic bit any_busy();
        foreach (m_busy_s[i]) if (m_busy_s[i]) return 1'b1;
        foreach (m_busy_p[i]) if (m_busy_p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        foreach (m_busy_s[i]) m_busy_s[i] = 1'b0;
        foreach (m_busy_p[i]) m_busy_p[i] = 1'b0;
        m_br_wait = 0; m_draining = 0; m_halted = 0; m_out_valid = 0;
        m_stall = '0;
        exp_q.delete();
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'($urandom); in_inst = $urandom; out_ready = 1'b0;
        wb_valid = 1'($urandom); wb_regbank_sel = 1'($urandom); wb_addr = 5'($urandom);
        br_resolve = 1'($urandom);
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic cycle(input bit iv, input logic [31:0] inst, input bit ordy,
                         input bit wv, input bit wbank, input logic [4:0] wa, input bit br);
        bit exp_ready, accept, halt_cond;
        @(negedge clk);
        rst = 1'b0;
        in_valid = iv; in_inst = inst; out_ready = ordy;
        wb_valid = wv; wb_regbank_sel = wbank; wb_addr = wa; br_resolve = br;
        #1;
        exp_ready = !m_br_wait && !m_draining && !m_halted && !m_hazard(inst)
                    && (!m_out_valid || ordy);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        check("out_valid", {31'b0, out_valid}, {31'b0, m_out_valid});
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        check("stall_cycles", stall_cycles, m_stall);
        accept = iv && exp_ready;
        if (accept) exp_q.push_back(inst);
        halt_cond = m_draining && !any_busy() && !m_out_valid;
        if (m_br_wait && br) m_br_wait = 0;
        if (halt_cond) begin m_draining = 0; m_halted = 1; end
        if (iv && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (wv) begin
            if (wbank) m_busy_p[wa[3:0]] = 1'b0;
            else       m_busy_s[wa] = 1'b0;
        end
        if (accept) begin
            m_out_valid = 1;
            if (writes(inst)) begin
                if (inst[27]) m_busy_p[inst[25:22]] = 1'b1;
                else          m_busy_s[inst[26:22]] = 1'b1;
            end
            if (inst[31:28] == OP_BR)   m_br_wait = 1;
            if (inst[31:28] == OP_HALT) m_draining = 1;
        end else if (ordy) begin
            m_out_valid = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 32'h0, 1, 0, 0, 0, 0);
    endtask

    // Output-slot monitor: whatever the DUT shows must be the oldest accepted word.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL out_unexpected: got %0h expected no valid output at %0t", out_inst, $time);
            end else begin
                check("out_inst", out_inst, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        int r = $urandom_range(0, 99);
        logic [3:0] op;
        bit zb = 1'($urandom), ab = 1'($urandom);
        logic [4:0] za = zb ? 5'($urandom) : 5'($urandom_range(0, 7));
        logic [4:0] aa = ab ? 5'($urandom) : 5'($urandom_range(0, 7));
        if (r < 3)       op = OP_HALT;
        else if (r < 10) op = OP_BR;
        else             op = 4'($urandom_range(0, 3));
        return mk(op, zb, za, $urandom_range(0, 3) != 0, ab, aa,
                  1'($urandom), 5'($urandom_range(0, 7)));
    endfunction

    task automatic pick_wb(output bit v, output bit bank, output logic [4:0] addr);
        int cand[$];
        int c;
        v = 0; bank = 0; addr = '0;
        foreach (m_busy_s[i]) if (m_busy_s[i]) cand.push_back(i);
        foreach (m_busy_p[i]) if (m_busy_p[i]) cand.push_back(100 + i);
        if (cand.size() != 0 && $urandom_range(0, 9) < 4) begin
            c = cand[$urandom_range(0, cand.size() - 1)];
            v = 1;
            if (c >= 100) begin bank = 1; addr = {1'($urandom), 4'(c - 100)}; end
            else          addr = 5'(c);
        end else if ($urandom_range(0, 9) == 0) begin
            v = 1; bank = 1'($urandom); addr = 5'($urandom);
        end
    endtask

    initial begin
        logic [31:0] add, sub, mov7, rd7, br, add2, cmp, hlt, a1, a2;
        bit wv, wbank, ordy;
        logic [4:0] wa;
        int halted_for;

        // RAW stall on s3, released one cycle after its writeback
        do_reset();
        add = mk(OP_ADD, 0, 3, 1, 0, 1, 1, 2);
        sub = mk(OP_SUB, 0, 4, 1, 0, 3, 1, 5);
        cycle(1, add, 1, 0, 0, 0, 0);
        repeat (3) cycle(1, sub, 1, 0, 0, 0, 0);
        cycle(1, sub, 1, 1, 0, 3, 0);
        cycle(1, sub, 1, 0, 0, 0, 0);
        cycle(0, sub, 1, 0, 0, 0, 0);
        check("raw_stall_count", stall_cycles, 32'd4);

        // Same-cycle retire and issue on s7: the issuing write wins
        do_reset();
        mov7 = mk(OP_MOV, 0, 7, 0, 0, 0, 0, 0);
        rd7  = mk(OP_ADD, 0, 8, 1, 0, 7, 0, 0);
        cycle(1, mov7, 1, 1, 0, 7, 0);
        repeat (3) cycle(1, rd7, 1, 0, 0, 0, 0);
        check("set_wins_stall", {31'b0, in_ready}, 32'd0);
        cycle(1, mov7, 1, 1, 0, 7, 0);
        cycle(1, mov7, 1, 0, 0, 0, 0);
        repeat (2) cycle(1, rd7, 1, 0, 0, 0, 0);

        // Branch serialisation; a resolve pulse in RUN is ignored
        do_reset();
        add  = mk(OP_ADD, 0, 10, 1, 0, 1, 0, 0);
        add2 = mk(OP_ADD, 0, 11, 1, 0, 1, 0, 0);
        br   = mk(OP_BR, 0, 0, 1, 1, 2, 0, 0);
        cycle(0, add, 1, 0, 0, 0, 1);
        cycle(1, add, 1, 0, 0, 0, 0);
        cycle(1, br, 1, 0, 0, 0, 0);
        repeat (3) cycle(1, add2, 1, 0, 0, 0, 0);
        cycle(1, add2, 1, 0, 0, 0, 1);
        cycle(1, add2, 1, 0, 0, 0, 0);
        idle(2);

        // Halt drain behind an outstanding predicate write
        do_reset();
        cmp = mk(OP_CMP, 1, 1, 1, 0, 2, 1, 3);
        hlt = mk(OP_HALT, 0, 0, 0, 0, 0, 0, 0);
        add = mk(OP_ADD, 0, 5, 0, 0, 0, 0, 0);
        cycle(1, cmp, 1, 0, 0, 0, 0);
        cycle(1, hlt, 1, 0, 0, 0, 0);
        repeat (5) cycle(1, add, 1, 0, 0, 0, 0);
        check("halt_not_early", {31'b0, halted}, 32'd0);
        cycle(1, add, 1, 1, 1, 5'h11, 0);
        repeat (4) cycle(1, add, 1, 0, 0, 0, 0);
        check("halt_reached", {31'b0, halted}, 32'd1);

        // Backpressure holds the slot, release replaces it on the same edge
        do_reset();
        a1 = mk(OP_ADD, 0, 1, 0, 0, 0, 0, 0);
        a2 = mk(OP_ADD, 0, 2, 0, 0, 0, 0, 0);
        cycle(1, a1, 0, 0, 0, 0, 0);
        repeat (3) cycle(1, a2, 0, 0, 0, 0, 0);
        cycle(1, a2, 1, 0, 0, 0, 0);
        cycle(0, a2, 1, 0, 0, 0, 0);
        idle(1);

        // Reset while waiting on a branch with three busy registers
        do_reset();
        cycle(1, mk(OP_ADD, 0, 1, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
        cycle(1, mk(OP_ADD, 0, 2, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
        cycle(1, mk(OP_ADD, 1, 3, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
        cycle(1, mk(OP_BR, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
        repeat (2) cycle(1, mk(OP_ADD, 0, 9, 1, 0, 1, 1, 2), 1, 0, 0, 0, 0);
        do_reset();
        cycle(1, mk(OP_ADD, 0, 1, 1, 0, 2, 1, 3), 1, 0, 0, 0, 0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        idle(1);

        // Randomized traffic
        halted_for = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_halted) halted_for++;
            if (halted_for > 3 || $urandom_range(0, 599) == 0) begin
                do_reset();
                halted_for = 0;
            end else begin
                pick_wb(wv, wbank, wa);
                ordy = ($urandom_range(0, 3) != 0);
                cycle($urandom_range(0, 3) != 0, rand_inst(), ordy, wv, wbank, wa,
                      m_br_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0));
            end
        end

        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
